beepboop_ser_arb: RTL

Round-robin arbiter and serializer for the beepboop 2-wire serial status channel: output bit 7 is the valid strobe and bit 6 is the data bit. It shares the channel between `NREQ` byte-stream requesters, for example the identifier streamer and the event reporter. A requester holds the grant for a whole null-terminated message, so strings never interleave. Each byte goes out MSB-first over 8 consecutive valid-strobed cycles.

---
 rtl/beepboop_ser_arb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/beepboop_ser_arb.sv
// Round-robin arbiter + MSB-first serializer for the 2-wire status channel (valid strobe + data bit).
// Latency: grant 1 cycle after valid in IDLE, accept in LOAD, 8 bit cycles; peak rate 1 byte per 9 cycles.
// Backpressure: req_ready only in LOAD for the grantee; BEEPBOOP_ARB_TIMEOUT_EN forces a terminator on a stalled grantee.
module beepboop_ser_arb #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     grant,
  output logic                ser_valid,
  output logic                ser_data,
  output logic                busy
);

  localparam int RRW = (NREQ > 2) ? 2 : 1;

  if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_param
    $error("beepboop_ser_arb: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [RRW-1:0]   rr_q, rr_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_q, bit_d;
  logic             zero_q, zero_d;
`ifdef BEEPBOOP_ARB_TIMEOUT_EN
  logic [7:0]       stall_q, stall_d;
`endif

  logic             own_valid;
  logic [7:0]       own_data;
  logic [RRW-1:0]   own_idx;
  logic             pick_vld;
  logic [RRW-1:0]   pick_idx;

  // Grantee view: the registered one-hot grant selects its valid and byte.
  always_comb begin
    own_valid = |(req_valid & grant_q);
    own_data  = 8'h00;
    own_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        own_data = req_data[8*i +: 8];
        own_idx  = RRW'(i);
      end
    end
  end

  // First valid requester at or after rr, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_idx = RRW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    zero_d  = zero_q;
`ifdef BEEPBOOP_ARB_TIMEOUT_EN
    stall_d = stall_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = LOAD;
        end
      end
      LOAD: begin
        if (own_valid) begin
          shreg_d = own_data;
          zero_d  = (own_data == 8'h00);
          bit_d   = 3'd0;
`ifdef BEEPBOOP_ARB_TIMEOUT_EN
          stall_d = 8'd0;
`endif
          state_d = SHIFT;
        end
`ifdef BEEPBOOP_ARB_TIMEOUT_EN
        // Stalled grantee: inject a terminator so the channel is released.
        else if (stall_q == 8'(TIMEOUT_CYC - 1)) begin
          shreg_d = 8'h00;
          zero_d  = 1'b1;
          bit_d   = 3'd0;
          stall_d = 8'd0;
          state_d = SHIFT;
        end else begin
          stall_d = stall_q + 8'd1;
        end
`endif
      end
      SHIFT: begin
        shreg_d = {shreg_q[6:0], 1'b0};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          if (zero_q) begin
            grant_d = '0;
            rr_d    = RRW'((int'(own_idx) + 1) % NREQ);
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      shreg_q <= 8'h00;
      bit_q   <= 3'd0;
      zero_q  <= 1'b0;
`ifdef BEEPBOOP_ARB_TIMEOUT_EN
      stall_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      zero_q  <= zero_d;
`ifdef BEEPBOOP_ARB_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign req_ready = grant_q & {NREQ{state_q == LOAD}};
  assign grant     = grant_q;
  assign ser_valid = (state_q == SHIFT);
  assign ser_data  = (state_q == SHIFT) & shreg_q[7];
  assign busy      = (state_q != IDLE);

endmodule
